// File: rtl/mips_mem_pkg.sv
// Shared Mips memory-side definitions: access size codes, bridge FSM states and
// the big-endian lane selection used by the SRAM bridge.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_e;

    // Masks are active-low, matching the SRAM pins.
    typedef struct packed {
        logic two_phase;
        logic hb_n;
        logic lb_n;
        logic misaligned;
    } lane_sel_t;

    function automatic lane_sel_t lane_select(input logic [1:0] size, input logic [1:0] a);
        lane_sel_t s;
        s = '{two_phase: 1'b0, hb_n: 1'b0, lb_n: 1'b0, misaligned: 1'b0};
        case (size)
            SZ_BYTE: begin
                s.hb_n = a[0];
                s.lb_n = ~a[0];
            end
            SZ_HALF: s.misaligned = a[0];
            default: begin
                s.two_phase  = 1'b1;
                s.misaligned = |a;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_phy.sv
// SRAM data-bus pad: tristate write driver plus the load-result capture register,
// so the FSM never touches the inout directly.
module sram_phy (
    input  logic        clock,
    input  logic        reset,
    input  logic        drive_en,
    input  logic [15:0] wr_half,
    input  logic        cap_en,
    input  logic [31:0] cap_word,
    output logic [15:0] din,
    output logic [31:0] rd_word,
    inout  wire  [15:0] data
);

    logic [31:0] rd_word_d, rd_word_q;

    assign data    = drive_en ? wr_half : 16'hzzzz;
    assign din     = data;
    assign rd_word = rd_word_q;

    always_comb begin
        rd_word_d = rd_word_q;
        if (cap_en) rd_word_d = cap_word;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rd_word_q <= '0;
        else        rd_word_q <= rd_word_d;
    end

endmodule

// File: rtl/sram_bridge.sv
// 32-bit Mips load/store to 16-bit async SRAM bridge (big-endian, word = two halfword phases).
// Optional SRAM_BRIDGE_ALIGN_CHECK_EN adds cpu_err and short-circuits misaligned accesses.
module sram_bridge
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_busy,
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    output logic              cpu_err,
`endif
    output logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e            state_d, state_q;
    logic              phase_d, phase_q;
    logic [WCW-1:0]    wcnt_d, wcnt_q;
    logic              we_d, we_q, byte_d, byte_q, two_d, two_q, hb_d, hb_q, lb_d, lb_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [15:0]       hi_d, hi_q;
    lane_sel_t         lane;
    logic              cap_en, drive_en, active;
    logic [31:0]       cap_word;
    logic [15:0]       wr_half, din;

    assign lane = lane_select(cpu_size, cpu_addr[1:0]);

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    logic err_d, err_q;
    assign cpu_err = (state_q == ST_DONE) && err_q;
`else
    logic unused_misalign;
    assign unused_misalign = lane.misaligned;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        two_d   = two_q;
        hb_d    = hb_q;
        lb_d    = lb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        cap_en  = 1'b0;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: if (cpu_req) begin
                we_d    = cpu_we;
                byte_d  = (cpu_size == SZ_BYTE);
                two_d   = lane.two_phase;
                hb_d    = lane.hb_n;
                lb_d    = lane.lb_n;
                // Words always start on an even halfword; low address bits are dropped.
                addr_d  = lane.two_phase ? {cpu_addr[ADDR_W:2], 1'b0} : cpu_addr[ADDR_W:1];
                wdata_d = cpu_wdata;
                phase_d = 1'b0;
                state_d = ST_SETUP;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
                err_d   = lane.misaligned;
                if (lane.misaligned) state_d = ST_DONE;
`endif
            end
            ST_SETUP: begin
                wcnt_d  = '0;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (wcnt_q == WCW'(WAIT_CYCLES)) begin
                    if (!we_q) begin
                        if (two_q && !phase_q) hi_d = din;
                        else                   cap_en = 1'b1;
                    end
                    if (two_q && !phase_q) begin
                        phase_d = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (two_q)       cap_word = {hi_q, din};
        else if (byte_q) cap_word = {24'h0, lb_q ? din[15:8] : din[7:0]};
        else             cap_word = {16'h0, din};

        if (two_q)       wr_half = phase_q ? wdata_q[15:0] : wdata_q[31:16];
        else if (byte_q) wr_half = {2{wdata_q[7:0]}};
        else             wr_half = wdata_q[15:0];
    end

    assign active    = (state_q == ST_SETUP) || (state_q == ST_STROBE);
    assign drive_en  = active && we_q;
    assign chip_en   = ~active;
    assign hb_mask   = active ? hb_q : 1'b1;
    assign lb_mask   = active ? lb_q : 1'b1;
    assign wre       = ~((state_q == ST_STROBE) && we_q);
    assign oute      = ~((state_q == ST_STROBE) && !we_q);
    assign addr      = addr_q;
    assign cpu_ready = (state_q == ST_DONE);
    assign cpu_busy  = (state_q != ST_IDLE);

    sram_phy u_phy (
        .clock    (clock),
        .reset    (reset),
        .drive_en (drive_en),
        .wr_half  (wr_half),
        .cap_en   (cap_en),
        .cap_word (cap_word),
        .din      (din),
        .rd_word  (cpu_rdata),
        .data     (data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            two_q   <= 1'b0;
            hb_q    <= 1'b1;
            lb_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            two_q   <= two_d;
            hb_q    <= hb_d;
            lb_q    <= lb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: two instances (WAIT_CYCLES 0 and 2) each on a behavioural async SRAM.
`timescale 1ns/1ps
module tb_sram_bridge;
    import mips_mem_pkg::*;

    localparam int AW = 18;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          req0 = 1'b0, reqw = 1'b0, we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW:0]   baddr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata0, rdataw;
    logic          rdy0, rdyw, busy0, busyw;
    logic [AW-1:0] addr0, addrw;
    wire  [15:0]   data0, dataw;
    logic          wre0, oute0, hb0, lb0, ce0, wrew, outew, hbw, lbw, cew;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    logic          err0, errw;
`endif

    logic [15:0] mem0 [0:2**AW-1];
    logic [15:0] memw [0:2**AW-1];

    // Undriven bus floats high, so an 0xFFFF read-back means nobody drives it.
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (data0[g]);
        pullup (dataw[g]);
    end

    assign data0 = (!ce0 && !oute0) ? mem0[addr0] : 16'hzzzz;
    assign dataw = (!cew && !outew) ? memw[addrw] : 16'hzzzz;

    always @(posedge clock) begin
        if (!ce0 && !wre0) begin
            if (!hb0) mem0[addr0][15:8] <= data0[15:8];
            if (!lb0) mem0[addr0][7:0]  <= data0[7:0];
        end
        if (!cew && !wrew) begin
            if (!hbw) memw[addrw][15:8] <= dataw[15:8];
            if (!lbw) memw[addrw][7:0]  <= dataw[7:0];
        end
    end

    sram_bridge #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut (
        .clock(clock), .reset(reset), .cpu_req(req0), .cpu_we(we), .cpu_size(size),
        .cpu_addr(baddr), .cpu_wdata(wdata), .cpu_rdata(rdata0), .cpu_ready(rdy0),
        .cpu_busy(busy0),
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        .cpu_err(err0),
`endif
        .addr(addr0), .data(data0), .wre(wre0), .oute(oute0), .hb_mask(hb0),
        .lb_mask(lb0), .chip_en(ce0)
    );

    sram_bridge #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut_w (
        .clock(clock), .reset(reset), .cpu_req(reqw), .cpu_we(we), .cpu_size(size),
        .cpu_addr(baddr), .cpu_wdata(wdata), .cpu_rdata(rdataw), .cpu_ready(rdyw),
        .cpu_busy(busyw),
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        .cpu_err(errw),
`endif
        .addr(addrw), .data(dataw), .wre(wrew), .oute(outew), .hb_mask(hbw),
        .lb_mask(lbw), .chip_en(cew)
    );

    bit          sel = 1'b0;
    logic        o_rdy, o_busy, o_wre, o_oute, o_hb, o_lb, o_ce, o_err;
    logic [31:0] o_rdata;
    logic [15:0] o_data;

    always_comb begin
        o_rdy   = sel ? rdyw   : rdy0;
        o_busy  = sel ? busyw  : busy0;
        o_wre   = sel ? wrew   : wre0;
        o_oute  = sel ? outew  : oute0;
        o_hb    = sel ? hbw    : hb0;
        o_lb    = sel ? lbw    : lb0;
        o_ce    = sel ? cew    : ce0;
        o_rdata = sel ? rdataw : rdata0;
        o_data  = sel ? dataw  : data0;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        o_err   = sel ? errw   : err0;
`else
        o_err   = 1'b0;
`endif
    end

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit          mon_ce_low, mon_busy_ok, mon_err;
    int          mon_oute_cnt;
    logic [1:0]  mon_masks;
    logic [15:0] mon_bus;
    logic [31:0] mon_rdata;

    task automatic issue(input bit s, input bit push, input bit w, input logic [1:0] sz,
                         input logic [AW:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input int lat);
        exp_t e;
        e.rdata = exp_rd;
        e.lat   = lat;
        if (push) sb.push_back(e);
        sel = s;
        @(negedge clock);
        we = w; size = sz; baddr = a; wdata = d;
        if (s) reqw = 1'b1;
        else   req0 = 1'b1;
        @(posedge clock);
        #1;
        req0 = 1'b0;
        reqw = 1'b0;
    endtask

    // Latency counts negedges from the accepting edge; 0 means no ready within the budget.
    task automatic wait_ready(output int lat);
        lat = 0;
        mon_ce_low = 1'b0; mon_busy_ok = 1'b1; mon_oute_cnt = 0; mon_err = 1'b0;
        mon_masks = 2'b11; mon_bus = 16'h0; mon_rdata = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (!o_ce) mon_ce_low = 1'b1;
            if (!o_oute) mon_oute_cnt++;
            if (!o_wre || !o_oute) mon_masks = {o_hb, o_lb};
            if (!o_wre) mon_bus = o_data;
            if (!o_busy) mon_busy_ok = 1'b0;
            if (o_rdy) begin
                lat = i; mon_rdata = o_rdata; mon_err = o_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if ({wre0, oute0, hb0, lb0, ce0} !== 5'b11111) begin n_bad++; $display("FAIL rst_strobes0: got %b want 11111", {wre0, oute0, hb0, lb0, ce0}); end
        n_cmp++; if ({wrew, outew, hbw, lbw, cew} !== 5'b11111) begin n_bad++; $display("FAIL rst_strobesw: got %b want 11111", {wrew, outew, hbw, lbw, cew}); end
        n_cmp++; if (data0 !== 16'hFFFF) begin n_bad++; $display("FAIL rst_bus: got %h want undriven", data0); end
        n_cmp++; if ({busy0, rdy0} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_ready: got %b want 00", {busy0, rdy0}); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata0); end
        n_cmp++; if (addr0 !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", addr0); end
    endtask

    task automatic test_word();
        int lat; exp_t e;
        issue(0, 1, 1'b1, SZ_WORD, 19'h10, 32'hDEADBEEF, 32'h0, 5);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL word_st_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (!mon_busy_ok) begin n_bad++; $display("FAIL word_st_busy: got dropped want held"); end
        n_cmp++; if ({mem0[8], mem0[9]} !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_st_mem: got %h%h want deadbeef", mem0[8], mem0[9]); end
        issue(0, 1, 1'b0, SZ_WORD, 19'h10, 32'h0, 32'hDEADBEEF, 5);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL word_ld_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (mon_rdata !== e.rdata) begin n_bad++; $display("FAIL word_ld_data: got %h want %h", mon_rdata, e.rdata); end
        repeat (3) @(negedge clock);
        n_cmp++; if (rdata0 !== 32'hDEADBEEF || busy0 !== 1'b0) begin n_bad++; $display("FAIL word_ld_hold: got %h/%b want deadbeef/0", rdata0, busy0); end
    endtask

    task automatic test_byte_half();
        int lat; exp_t e;
        mem0[16] <= 16'h1234;
        issue(0, 1, 1'b1, SZ_BYTE, 19'h21, 32'h000000A5, 32'h0, 3);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL byte_st_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (mon_masks !== 2'b10) begin n_bad++; $display("FAIL byte_st_mask: got %b want 10", mon_masks); end
        n_cmp++; if (mon_bus !== 16'hA5A5) begin n_bad++; $display("FAIL byte_st_bus: got %h want a5a5", mon_bus); end
        n_cmp++; if (mem0[16] !== 16'h12A5) begin n_bad++; $display("FAIL byte_st_mem: got %h want 12a5", mem0[16]); end
        issue(0, 1, 1'b0, SZ_BYTE, 19'h20, 32'h0, 32'h00000012, 3);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat || mon_rdata !== e.rdata) begin n_bad++; $display("FAIL byte_ld_hi: got %0d/%h want %0d/%h", lat, mon_rdata, e.lat, e.rdata); end
        n_cmp++; if (mon_masks !== 2'b01) begin n_bad++; $display("FAIL byte_ld_mask: got %b want 01", mon_masks); end
        issue(0, 1, 1'b0, SZ_BYTE, 19'h21, 32'h0, 32'h000000A5, 3);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat || mon_rdata !== e.rdata) begin n_bad++; $display("FAIL byte_ld_lo: got %0d/%h want %0d/%h", lat, mon_rdata, e.lat, e.rdata); end
        issue(0, 1, 1'b1, SZ_HALF, 19'h40, 32'h1234CAFE, 32'h0, 3);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat || mon_masks !== 2'b00) begin n_bad++; $display("FAIL half_st: got %0d/%b want %0d/00", lat, mon_masks, e.lat); end
        n_cmp++; if (mem0[32] !== 16'hCAFE) begin n_bad++; $display("FAIL half_st_mem: got %h want cafe", mem0[32]); end
    endtask

    task automatic test_wait();
        int lat; exp_t e;
        memw[18'h55] <= 16'hC0DE;
        issue(1, 1, 1'b0, SZ_HALF, 19'hAA, 32'h0, 32'h0000C0DE, 5);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL wait_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (mon_oute_cnt != 3) begin n_bad++; $display("FAIL wait_oute: got %0d want 3", mon_oute_cnt); end
        n_cmp++; if (mon_rdata !== e.rdata) begin n_bad++; $display("FAIL wait_data: got %h want %h", mon_rdata, e.rdata); end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back_top();
        int lat, nrdy; exp_t e;
        issue(0, 1, 1'b1, SZ_WORD, 19'h7FFFC, 32'h11223344, 32'h0, 5);
        lat = 0; nrdy = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock);
            if (i == 2) req0 = 1'b1;
            if (i == 3) req0 = 1'b0;
            if (rdy0) begin nrdy++; if (lat == 0) lat = i; end
        end
        e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL top_st_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (nrdy != 1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL top_one_ready: got %0d/%b want 1/0", nrdy, busy0); end
        n_cmp++; if ({mem0[18'h3FFFE], mem0[18'h3FFFF]} !== 32'h11223344) begin n_bad++; $display("FAIL top_st_mem: got %h%h want 11223344", mem0[18'h3FFFE], mem0[18'h3FFFF]); end
        issue(0, 1, 1'b0, SZ_WORD, 19'h7FFFC, 32'h0, 32'h11223344, 5);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat || mon_rdata !== e.rdata) begin n_bad++; $display("FAIL top_ld: got %0d/%h want %0d/%h", lat, mon_rdata, e.lat, e.rdata); end
    endtask

    task automatic test_reset_mid();
        int nrdy; bit seen;
        mem0[48] <= 16'h0000;
        mem0[49] <= 16'h5555;
        issue(0, 0, 1'b1, SZ_WORD, 19'h60, 32'hAAAA0BBB, 32'h0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (!wre0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_strobe: got no wre low want wre low"); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if ({wre0, ce0, busy0} !== 3'b110) begin n_bad++; $display("FAIL rmid_strobes: got %b want 110", {wre0, ce0, busy0}); end
        n_cmp++; if (data0 !== 16'hFFFF) begin n_bad++; $display("FAIL rmid_bus: got %h want undriven", data0); end
        @(negedge clock);
        reset = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rdy0) nrdy++;
        end
        n_cmp++; if (nrdy != 0) begin n_bad++; $display("FAIL rmid_ready: got %0d want 0", nrdy); end
        n_cmp++; if (mem0[49] !== 16'h5555) begin n_bad++; $display("FAIL rmid_second: got %h want 5555", mem0[49]); end
    endtask

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    task automatic test_align();
        int lat; exp_t e;
        issue(0, 1, 1'b0, SZ_WORD, 19'h10, 32'h0, 32'hDEADBEEF, 5);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (mon_rdata !== e.rdata) begin n_bad++; $display("FAIL align_pre: got %h want %h", mon_rdata, e.rdata); end
        issue(0, 1, 1'b0, SZ_WORD, 19'h12, 32'h0, 32'hDEADBEEF, 1);
        wait_ready(lat); e = sb.pop_front();
        n_cmp++; if (lat != e.lat || mon_err !== 1'b1) begin n_bad++; $display("FAIL align_err: got %0d/%b want %0d/1", lat, mon_err, e.lat); end
        n_cmp++; if (mon_ce_low) begin n_bad++; $display("FAIL align_ce: got chip_en low want high"); end
        n_cmp++; if (mon_rdata !== e.rdata) begin n_bad++; $display("FAIL align_rdata: got %h want %h", mon_rdata, e.rdata); end
        @(negedge clock);
        n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL align_err_clr: got %b want 0", err0); end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_wait();
        test_back_to_back_top();
        test_reset_mid();
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        test_align();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
